// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Handshakes with the shared memory port (mem_ready) and the iterative MULT/DIV unit
// (alu_start/alu_done). The core halts on SYSCALL or on a memory timeout.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    input  logic       alu_done,
    output logic       mem_read,
    output logic       mem_write_en,
    output logic       i_or_d,
    output logic       ir_load,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       branch,
    output logic [5:0] alu_op,
    output logic       alu_src,
    output logic       alu_start,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       link,
    output logic       halted,
    output logic       bus_error,
    output logic [2:0] state
);

    // FSM state encoding (visible on the debug port)
    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    // Instruction classes latched in DECODE; jumps and SYSCALL never need one
    localparam logic [2:0] ClsNop    = 3'd0;
    localparam logic [2:0] ClsRtype  = 3'd1;
    localparam logic [2:0] ClsIalu   = 3'd2;
    localparam logic [2:0] ClsLoad   = 3'd3;
    localparam logic [2:0] ClsStore  = 3'd4;
    localparam logic [2:0] ClsBranch = 3'd5;
    localparam logic [2:0] ClsMulDiv = 3'd6;

    // Last wait cycle of an access; a miss on this cycle is a bus error
    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] cls_q, cls_d;
    logic [5:0] alu_op_q, alu_op_d;
    logic       alu_src_q, alu_src_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       bus_err_q, bus_err_d;

    logic [2:0] dec_cls;
    logic [5:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_jump;
    logic       dec_link;
    logic       dec_sys;
    logic       timeout_hit;

    assign timeout_hit = (cnt_q == TimeoutLast);

    // Instruction decode from the live IR fields
    always_comb begin
        dec_cls     = ClsNop;
        dec_alu_op  = 6'h00;
        dec_alu_src = 1'b0;
        dec_jump    = 1'b0;
        dec_link    = 1'b0;
        dec_sys     = 1'b0;
        case (opcode)
            6'h00: begin
                if (func == 6'h0C) begin
                    dec_sys = 1'b1;
                end else if (func == 6'h18 || func == 6'h1A) begin
                    dec_cls    = ClsMulDiv;
                    dec_alu_op = func;
                end else begin
                    dec_cls    = ClsRtype;
                    dec_alu_op = func;
                end
            end
            6'h02: dec_jump = 1'b1;
            6'h03: begin
                dec_jump = 1'b1;
                dec_link = 1'b1;
            end
            6'h08: begin dec_cls = ClsIalu; dec_alu_op = 6'h20; dec_alu_src = 1'b1; end
            6'h09: begin dec_cls = ClsIalu; dec_alu_op = 6'h21; dec_alu_src = 1'b1; end
            6'h0C: begin dec_cls = ClsIalu; dec_alu_op = 6'h24; dec_alu_src = 1'b1; end
            6'h0D: begin dec_cls = ClsIalu; dec_alu_op = 6'h25; dec_alu_src = 1'b1; end
            6'h0E: begin dec_cls = ClsIalu; dec_alu_op = 6'h26; dec_alu_src = 1'b1; end
            6'h0A: begin dec_cls = ClsIalu; dec_alu_op = 6'h2A; dec_alu_src = 1'b1; end
            6'h0F: begin dec_cls = ClsIalu; dec_alu_op = 6'h3D; dec_alu_src = 1'b1; end
            6'h23, 6'h20: begin
                dec_cls     = ClsLoad;
                dec_alu_op  = 6'h20;
                dec_alu_src = 1'b1;
            end
            6'h2B, 6'h28: begin
                dec_cls     = ClsStore;
                dec_alu_op  = 6'h20;
                dec_alu_src = 1'b1;
            end
            6'h04: begin dec_cls = ClsBranch; dec_alu_op = 6'h38; end
            6'h05: begin dec_cls = ClsBranch; dec_alu_op = 6'h39; end
            6'h06: begin dec_cls = ClsBranch; dec_alu_op = 6'h3A; end
            6'h07: begin dec_cls = ClsBranch; dec_alu_op = 6'h3B; end
            6'h01: begin dec_cls = ClsBranch; dec_alu_op = 6'h3C; end
            default: ;
        endcase
    end

    // Next state, class latch, memory timeout counter and MULT/DIV busy tracking
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        cnt_d     = 8'd0;
        busy_d    = 1'b0;
        bus_err_d = bus_err_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDecode: begin
                cls_d     = dec_cls;
                alu_op_d  = dec_alu_op;
                alu_src_d = dec_alu_src;
                if (dec_sys) begin
                    state_d = StHalt;
                end else if (dec_jump || dec_cls == ClsNop) begin
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsMulDiv: begin
                        // busy_q marks that the start pulse has already gone out
                        if (alu_done) begin
                            state_d = StFetch;
                        end else begin
                            busy_d = 1'b1;
                        end
                    end
                    ClsBranch:          state_d = StFetch;
                    ClsLoad, ClsStore:  state_d = StMem;
                    ClsRtype, ClsIalu:  state_d = StWb;
                    default:            state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsLoad) ? StWb : StFetch;
                end else if (timeout_hit) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StFetch;
            cls_q     <= ClsNop;
            alu_op_q  <= 6'h00;
            alu_src_q <= 1'b0;
            cnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Control outputs; gated by rst_b so requests drop the instant reset asserts
    always_comb begin
        mem_read     = 1'b0;
        mem_write_en = 1'b0;
        i_or_d       = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        branch       = 1'b0;
        alu_op       = 6'h00;
        alu_src      = 1'b0;
        alu_start    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        link         = 1'b0;
        halted       = 1'b0;
        if (rst_b) begin
            case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'd0;
                    end
                end
                StDecode: begin
                    if (!dec_sys && dec_jump) begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = dec_link;
                        link      = dec_link;
                    end
                end
                StExec: begin
                    alu_op  = alu_op_q;
                    alu_src = alu_src_q;
                    if (cls_q == ClsBranch) begin
                        branch = 1'b1;
                        pc_src = 2'd1;
                    end
                    if (cls_q == ClsMulDiv) begin
                        alu_start = !busy_q;
                    end
                end
                StMem: begin
                    alu_op       = alu_op_q;
                    alu_src      = alu_src_q;
                    i_or_d       = 1'b1;
                    mem_read     = (cls_q == ClsLoad);
                    mem_write_en = (cls_q == ClsStore);
                end
                StWb: begin
                    alu_op     = alu_op_q;
                    alu_src    = alu_src_q;
                    reg_write  = 1'b1;
                    reg_dst    = (cls_q == ClsRtype);
                    mem_to_reg = (cls_q == ClsLoad);
                end
                StHalt:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus_error = bus_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_TIMEOUT = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Observed vector: {state, mr, mw, i_or_d, ir_load, pc_write, pc_src, branch, alu_op,
//                   alu_src, alu_start, reg_write, reg_dst, mem_to_reg, link, halted, bus_error}
module tb_multicycle_sequencer;

    logic       clk;
    logic       rst_b;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       mem_ready;
    logic       alu_done;
    logic       mem_read, mem_write_en, i_or_d, ir_load, pc_write, branch;
    logic [1:0] pc_src;
    logic [5:0] alu_op;
    logic       alu_src, alu_start, reg_write, reg_dst, mem_to_reg, link, halted, bus_error;
    logic [2:0] state;

    logic [24:0] got_v;
    logic [24:0] exp_v;
    int          total;
    int          bad;

    localparam logic [24:0] VZero      = 25'd0;
    localparam logic [24:0] VFetchRdy  = {3'd0, 5'b10011, 2'd0, 1'b0, 6'h00, 8'b0000_0000};
    localparam logic [24:0] VFetchWait = {3'd0, 5'b10000, 2'd0, 1'b0, 6'h00, 8'b0000_0000};
    localparam logic [24:0] VDecode    = {3'd1, 5'b00000, 2'd0, 1'b0, 6'h00, 8'b0000_0000};

    assign got_v = {state, mem_read, mem_write_en, i_or_d, ir_load, pc_write, pc_src, branch,
                    alu_op, alu_src, alu_start, reg_write, reg_dst, mem_to_reg, link, halted,
                    bus_error};

    multicycle_sequencer #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .opcode      (opcode),
        .func        (func),
        .mem_ready   (mem_ready),
        .alu_done    (alu_done),
        .mem_read    (mem_read),
        .mem_write_en(mem_write_en),
        .i_or_d      (i_or_d),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .branch      (branch),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .alu_start   (alu_start),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .link        (link),
        .halted      (halted),
        .bus_error   (bus_error),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset for two cycles, release on a falling edge (first FETCH cycle begins)
    task automatic do_reset();
        rst_b     = 1'b0;
        mem_ready = 1'b0;
        alu_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        opcode    = 6'h03;
        func      = 6'h0C;
        mem_ready = 1'b1;
        alu_done  = 1'b1;
        #1 rst_b  = 1'b0;
        @(negedge clk);
        #1;
        exp_v = VZero;
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_add();
        do_reset();
        opcode = 6'h00; func = 6'h20; mem_ready = 1'b1;
        #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL add_fetch got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = VDecode; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL add_decode got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = {3'd2, 5'b00000, 2'd0, 1'b0, 6'h20, 8'b0000_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL add_exec got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = {3'd4, 5'b00000, 2'd0, 1'b0, 6'h20, 8'b0011_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL add_wb got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL add_refetch got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_load_wait();
        do_reset();
        opcode = 6'h23; func = 6'h00; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0; #1;
        exp_v = {3'd2, 5'b00000, 2'd0, 1'b0, 6'h20, 8'b1000_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL lw_exec got=%h exp=%h", got_v, exp_v); end
        // Three wait cycles, then ready on the fourth (the last legal cycle with MEM_TIMEOUT=4)
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i == 3); #1;
            exp_v = {3'd3, 5'b10100, 2'd0, 1'b0, 6'h20, 8'b1000_0000}; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL lw_mem cycle=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        exp_v = {3'd4, 5'b00000, 2'd0, 1'b0, 6'h20, 8'b1010_1000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL lw_wb got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = VFetchWait; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL lw_refetch got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_muldiv();
        int starts;
        do_reset();
        opcode = 6'h00; func = 6'h18; mem_ready = 1'b1;
        // alu_done during DECODE must be ignored
        @(negedge clk); alu_done = 1'b1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); alu_done = (i == 5); #1;
            starts += int'(alu_start);
            exp_v = {3'd2, 5'b00000, 2'd0, 1'b0, 6'h18, (i == 0) ? 8'b0100_0000 : 8'b0000_0000};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL mult_exec cycle=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        total++;
        if (starts !== 1) begin bad++; $display("FAIL mult_start_count got=%0d exp=1", starts); end
        @(negedge clk); alu_done = 1'b0; #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL mult_done got=%h exp=%h", got_v, exp_v); end
        // DIV completing in the same cycle as its start pulse
        func = 6'h1A;
        @(negedge clk);
        @(negedge clk); alu_done = 1'b1; #1;
        exp_v = {3'd2, 5'b00000, 2'd0, 1'b0, 6'h1A, 8'b0100_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL div_exec got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); alu_done = 1'b0; #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL div_done got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_branch();
        logic [5:0] ops  [5];
        logic [5:0] codes[5];
        ops   = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
        codes = '{6'h38, 6'h39, 6'h3A, 6'h3B, 6'h3C};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            opcode = ops[k]; func = 6'h00; mem_ready = 1'b1;
            @(negedge clk);
            @(negedge clk); #1;
            exp_v = {3'd2, 5'b00000, 2'd1, 1'b1, codes[k], 8'b0000_0000}; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL branch_exec op=%h got=%h exp=%h", ops[k], got_v, exp_v);
            end
            @(negedge clk); #1;
            exp_v = VFetchRdy; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL branch_next op=%h got=%h exp=%h", ops[k], got_v, exp_v);
            end
        end
    endtask

    task automatic test_jumps();
        do_reset();
        opcode = 6'h03; func = 6'h00; mem_ready = 1'b1;
        @(negedge clk); #1;
        exp_v = {3'd1, 5'b00001, 2'd2, 1'b0, 6'h00, 8'b0010_0100}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL jal_decode got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); opcode = 6'h02; #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL jal_next got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = {3'd1, 5'b00001, 2'd2, 1'b0, 6'h00, 8'b0000_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL j_decode got=%h exp=%h", got_v, exp_v); end
        // Undefined opcode behaves as a NOP
        @(negedge clk); opcode = 6'h3F;
        @(negedge clk); #1;
        exp_v = VDecode; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL nop_decode got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL nop_next got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_ialu_store();
        logic [5:0] ops  [4];
        logic [5:0] codes[4];
        ops   = '{6'h08, 6'h0C, 6'h0A, 6'h0F};
        codes = '{6'h20, 6'h24, 6'h2A, 6'h3D};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            opcode = ops[k]; func = 6'h25; mem_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk); #1;
            exp_v = {3'd4, 5'b00000, 2'd0, 1'b0, codes[k], 8'b1010_0000}; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ialu_wb op=%h got=%h exp=%h", ops[k], got_v, exp_v);
            end
        end
        do_reset();
        opcode = 6'h2B; func = 6'h00; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        exp_v = {3'd3, 5'b01100, 2'd0, 1'b0, 6'h20, 8'b1000_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL sw_mem got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL sw_next got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = 6'h00; func = 6'h20; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp_v = VFetchWait; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL tmo_wait cycle=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = (i == 2); #1;
            exp_v = {3'd5, 5'b00000, 2'd0, 1'b0, 6'h00, 8'b0000_0011}; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL tmo_halt cycle=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        // Ready on the fourth wait cycle completes the fetch
        do_reset();
        for (int i = 0; i < 3; i++) @(negedge clk);
        mem_ready = 1'b1; #1;
        exp_v = VFetchRdy; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL tmo_edge_fetch got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); #1;
        exp_v = VDecode; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL tmo_edge_decode got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_syscall();
        do_reset();
        opcode = 6'h00; func = 6'h0C; mem_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            mem_ready = i[0];
            alu_done  = i[1];
            #1;
            exp_v = {3'd5, 5'b00000, 2'd0, 1'b0, 6'h00, 8'b0000_0010}; total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL syscall_halt cycle=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        alu_done = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        opcode = 6'h23; func = 6'h00; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); #1;
        exp_v = {3'd3, 5'b10100, 2'd0, 1'b0, 6'h20, 8'b1000_0000}; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_pre_mem got=%h exp=%h", got_v, exp_v); end
        #1 rst_b = 1'b0;
        #1;
        exp_v = VZero; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_async got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); rst_b = 1'b1; #1;
        exp_v = VFetchWait; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_resume got=%h exp=%h", got_v, exp_v); end
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); #1;
        exp_v = VDecode; total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_decode got=%h exp=%h", got_v, exp_v); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_b     = 1'b1;
        opcode    = 6'h00;
        func      = 6'h00;
        mem_ready = 1'b0;
        alu_done  = 1'b0;
        test_reset();
        test_add();
        test_load_wait();
        test_muldiv();
        test_branch();
        test_jumps();
        test_ialu_store();
        test_timeout();
        test_syscall();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
